ram_ctrl: RTL and testbench

RAM_CTRL -- requirements
Module: ram_ctrl

---
 rtl/ram_ctrl.sv | 172 +++++++++++++++++
 tb/tb_ram_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_ctrl.sv
// Request/response controller for a single-port RAM with a registered read port.
// Define RAM_CTRL_BIST_EN to compile in the write-then-verify memory self-test.
module ram_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              bist_start,
    output logic              bist_busy,
    output logic              bist_done,
    output logic              bist_fail
);

    typedef enum logic [3:0] {
        IDLE, WR, RD, RCAP, RESP
`ifdef RAM_CTRL_BIST_EN
        , B_WR, B_WNXT, B_RD, B_RCAP
`endif
    } state_t;

    state_t            state, state_d;
    logic              ram_we_d, rsp_valid_d;
    logic [ADDR_W-1:0] ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_d, rsp_data_d;

`ifdef RAM_CTRL_BIST_EN
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    logic              busy_d, done_d, fail_d;
    logic [ADDR_W-1:0] next_addr;

    // Self-test pattern: inverted address, truncated or zero-extended to the data width.
    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
        return DATA_W'(~a);
    endfunction

    assign next_addr = ram_addr + 1'b1;
    assign req_ready = (state == IDLE) && !bist_start;
`else
    logic unused_bist_start;

    assign unused_bist_start = bist_start;
    assign req_ready = (state == IDLE);
    assign bist_busy = 1'b0;
    assign bist_done = 1'b0;
    assign bist_fail = 1'b0;
`endif

    // NOTE: every signal gets its hold/default value before the case, so no path
    // through this block leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d     = state;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr;
        ram_wdata_d = ram_wdata;
        rsp_valid_d = rsp_valid;
        rsp_data_d  = rsp_data;
`ifdef RAM_CTRL_BIST_EN
        busy_d      = bist_busy;
        done_d      = bist_done;
        fail_d      = bist_fail;
`endif
        case (state)
            IDLE: begin
`ifdef RAM_CTRL_BIST_EN
                if (bist_start) begin
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    fail_d      = 1'b0;
                    ram_addr_d  = '0;
                    ram_wdata_d = pattern('0);
                    ram_we_d    = 1'b1;
                    state_d     = B_WR;
                end else
`endif
                if (req_valid) begin
                    ram_addr_d  = req_addr;
                    ram_wdata_d = req_wdata;
                    ram_we_d    = req_write;
                    state_d     = req_write ? WR : RD;
                end
            end
            WR:   state_d = IDLE;
            RD:   state_d = RCAP;
            RCAP: begin
                rsp_data_d  = ram_rdata;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
`ifdef RAM_CTRL_BIST_EN
            B_WR: begin
                // The last write lands on this edge while the address rewinds for the read pass.
                if (ram_addr == ADDR_MAX) begin
                    ram_addr_d = '0;
                    state_d    = B_RD;
                end else begin
                    state_d = B_WNXT;
                end
            end
            B_WNXT: begin
                ram_addr_d  = next_addr;
                ram_wdata_d = pattern(next_addr);
                ram_we_d    = 1'b1;
                state_d     = B_WR;
            end
            B_RD: state_d = B_RCAP;
            B_RCAP: begin
                if (ram_rdata != pattern(ram_addr)) fail_d = 1'b1;
                if (ram_addr == ADDR_MAX) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    ram_addr_d = next_addr;
                    state_d    = B_RD;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // NOTE: registers are updated with non-blocking assignments so every flop
    // samples the values computed before this edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
`ifdef RAM_CTRL_BIST_EN
            bist_busy <= 1'b0;
            bist_done <= 1'b0;
            bist_fail <= 1'b0;
`endif
        end else begin
            state     <= state_d;
            ram_we    <= ram_we_d;
            ram_addr  <= ram_addr_d;
            ram_wdata <= ram_wdata_d;
            rsp_valid <= rsp_valid_d;
            rsp_data  <= rsp_data_d;
`ifdef RAM_CTRL_BIST_EN
            bist_busy <= busy_d;
            bist_done <= done_d;
            bist_fail <= fail_d;
`endif
        end
    end

endmodule

// File: tb/tb_ram_ctrl.sv
// Self-checking bench for ram_ctrl: behavioural registered-read RAM plus an
// expected-read-data queue filled at read accept and drained when a response arrives.
module tb_ram_ctrl;

    localparam int AW = 4;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic          bist_start, bist_busy, bist_done, bist_fail;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic stuck_en = 1'b0;
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] exp_q [$];

    ram_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .bist_start(bist_start), .bist_busy(bist_busy), .bist_done(bist_done), .bist_fail(bist_fail)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model; optional stuck-at-1 on bit 0 of address 5.
    always @(posedge clk) begin
        if (ram_we) begin
            if (stuck_en && ram_addr == 4'd5) mem[ram_addr] <= ram_wdata | 4'h1;
            else                             mem[ram_addr] <= ram_wdata;
        end else begin
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Presents one request, waits for acceptance, returns 1 ns after the accept edge.
    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
        while (!req_ready && n < 100) begin tick(); n++; end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL issue_timeout: req_ready=%0b after %0d cycles, need 1", req_ready, n);
        end
        tick();
        req_valid = 1'b0;
    endtask

    // Counts edges from the current point until rsp_valid is seen.
    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 100) begin tick(); lat++; end
    endtask

    task automatic consume;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic read_and_check(input logic [AW-1:0] a, input string name);
        int lat;
        logic [DW-1:0] exp;
        issue(1'b0, a, '0);
        exp_q.push_back(mem[a]);
        wait_rsp(lat);
        exp = exp_q.pop_front();
        checks++;
        if (lat !== 2 || rsp_data !== exp) begin
            errors++;
            $display("FAIL %s: latency %0d data %h, need latency 2 data %h", name, lat, rsp_data, exp);
        end
        consume();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        checks++;
        if ({req_ready, ram_we, rsp_valid, bist_busy, bist_done, bist_fail} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_ctrl: ready/we/vld/busy/done/fail=%b, need 100000",
                     {req_ready, ram_we, rsp_valid, bist_busy, bist_done, bist_fail});
        end
        checks++;
        if (ram_addr !== '0 || ram_wdata !== '0 || rsp_data !== '0) begin
            errors++;
            $display("FAIL reset_data: addr %h wdata %h rsp %h, need 0 0 0", ram_addr, ram_wdata, rsp_data);
        end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: %b, need 1", req_ready);
        end
    endtask

    task automatic test_write_read;
        int lat;
        logic [DW-1:0] exp;
        rsp_ready = 1'b1;  // must be ignored while no response is pending
        issue(1'b1, 4'h2, 4'hC);
        rsp_ready = 1'b0;
        checks++;
        if (ram_we !== 1'b1 || ram_addr !== 4'h2 || ram_wdata !== 4'hC || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL wr_cycle: we %b addr %h wdata %h ready %b, need 1 2 c 0",
                     ram_we, ram_addr, ram_wdata, req_ready);
        end
        tick();
        checks++;
        if (ram_we !== 1'b0 || req_ready !== 1'b1 || mem[2] !== 4'hC) begin
            errors++;
            $display("FAIL wr_done: we %b ready %b mem2 %h, need 0 1 c", ram_we, req_ready, mem[2]);
        end
        issue(1'b0, 4'h2, 4'h0);
        exp_q.push_back(4'hC);
        checks++;
        if (ram_we !== 1'b0) begin
            errors++;
            $display("FAIL rd_we: %b, need 0", ram_we);
        end
        wait_rsp(lat);
        exp = exp_q.pop_front();
        checks++;
        if (lat !== 2 || rsp_data !== exp) begin
            errors++;
            $display("FAIL rd_0x2: latency %0d data %h, need latency 2 data %h", lat, rsp_data, exp);
        end
        consume();
    endtask

    task automatic test_multi;
        issue(1'b1, 4'h0, 4'h8); tick();
        issue(1'b1, 4'h1, 4'hA); tick();
        issue(1'b1, 4'hA, 4'hC); tick();
        issue(1'b1, 4'hF, 4'h5); tick();
        read_and_check(4'h0, "rd_0x0");
        read_and_check(4'h1, "rd_0x1");
        read_and_check(4'hA, "rd_0xA");
        read_and_check(4'hF, "rd_0xF_top");
    endtask

    task automatic test_back_to_back;
        int t [4];
        req_valid = 1'b1; req_write = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int n = 0;
            req_addr = AW'(4 + i); req_wdata = DW'(i + 1);
            while (!req_ready && n < 20) begin tick(); n++; end
            t[i] = cyc;
            tick();
        end
        req_valid = 1'b0;
        tick();
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (t[i] - t[i-1] !== 2) begin
                errors++;
                $display("FAIL b2b_gap%0d: %0d cycles, need 2", i, t[i] - t[i-1]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[4 + i] !== DW'(i + 1)) begin
                errors++;
                $display("FAIL b2b_data%0d: %h, need %h", i, mem[4 + i], DW'(i + 1));
            end
        end
    endtask

    task automatic test_hold;
        int lat;
        logic [DW-1:0] exp;
        issue(1'b0, 4'h1, 4'h0);
        exp_q.push_back(4'hA);
        wait_rsp(lat);
        exp = exp_q.pop_front();
        // A second request is held throughout; it must wait, not vanish.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 4'hA;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== exp || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_c%0d: vld %b data %h ready %b, need 1 %h 0",
                         i, rsp_valid, rsp_data, req_ready, exp);
            end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: vld %b ready %b, need 0 1", rsp_valid, req_ready);
        end
        tick();
        req_valid = 1'b0;
        exp_q.push_back(4'hC);
        wait_rsp(lat);
        exp = exp_q.pop_front();
        checks++;
        if (lat !== 2 || rsp_data !== exp) begin
            errors++;
            $display("FAIL held_req: latency %0d data %h, need latency 2 data %h", lat, rsp_data, exp);
        end
        consume();
    endtask

    task automatic test_reset_rcap;
        issue(1'b0, 4'hA, 4'h0);
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || ram_we !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_rcap: vld %b we %b ready %b, need 0 0 1", rsp_valid, ram_we, req_ready);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
                errors++;
                $display("FAIL rst_rcap_after%0d: vld %b ready %b, need 0 1", i, rsp_valid, req_ready);
            end
        end
    endtask

`ifdef RAM_CTRL_BIST_EN
    task automatic run_bist(input string name);
        int n = 0;
        bist_start = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 4'h3; req_wdata = 4'h0;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_prio: req_ready %b, need 0", name, req_ready);
        end
        @(posedge clk); #0;
        #1;
        bist_start = 1'b0; req_valid = 1'b0;
        checks++;
        if (bist_busy !== 1'b1 || bist_done !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy: busy %b done %b, need 1 0", name, bist_busy, bist_done);
        end
        while (!bist_done && n < 300) begin tick(); n++; end
        checks++;
        if (bist_done !== 1'b1 || bist_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_end: done %b busy %b after %0d cycles, need 1 0", name, bist_done, bist_busy, n);
        end
    endtask

    task automatic test_bist;
        run_bist("bist_good");
        checks++;
        if (bist_fail !== 1'b0) begin
            errors++;
            $display("FAIL bist_good_fail: %b, need 0", bist_fail);
        end
        read_and_check(4'h3, "bist_addr3");
        checks++;
        if (mem[3] !== 4'hC) begin
            errors++;
            $display("FAIL bist_mem3: %h, need c", mem[3]);
        end
        stuck_en = 1'b1;
        run_bist("bist_stuck");
        checks++;
        if (bist_fail !== 1'b1) begin
            errors++;
            $display("FAIL bist_stuck_fail: %b, need 1", bist_fail);
        end
        stuck_en = 1'b0;
    endtask
`else
    task automatic test_bist_disabled;
        bist_start = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 4'h9; req_wdata = 4'h6;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL nobist_ready: %b, need 1", req_ready);
        end
        tick();
        bist_start = 1'b0; req_valid = 1'b0;
        checks++;
        if (ram_we !== 1'b1 || ram_addr !== 4'h9 || ram_wdata !== 4'h6) begin
            errors++;
            $display("FAIL nobist_accept: we %b addr %h wdata %h, need 1 9 6", ram_we, ram_addr, ram_wdata);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({bist_busy, bist_done, bist_fail} !== 3'b000) begin
                errors++;
                $display("FAIL nobist_status%0d: %b, need 000", i, {bist_busy, bist_done, bist_fail});
            end
            tick();
        end
    endtask
`endif

    initial begin
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0; bist_start = 1'b0;
        for (int i = 0; i < 2**AW; i++) mem[i] = '0;
        test_reset();
        test_write_read();
        test_multi();
        test_back_to_back();
        test_hold();
        test_reset_rcap();
`ifdef RAM_CTRL_BIST_EN
        test_bist();
`else
        test_bist_disabled();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
